// File: rtl/mib_pkg.sv
// Shared MIB bus definitions: phase field layout, slave FSM states and the cmd payload.
package mib_pkg;

  localparam int unsigned MIB_AD_BITS      = 16;
  localparam int unsigned MIB_ADDR_BITS    = 24;
  localparam int unsigned MIB_DATA_BITS    = 32;
  localparam int unsigned MIB_MSN_LSB      = 20;
  localparam int unsigned MIB_MSN_BITS     = 4;
  // A1 carries addr[23:16] in its low byte; A1[15:8] is don't-care.
  localparam int unsigned MIB_A1_ADDR_BITS = 8;
  localparam int unsigned MIB_A1_ADDR_LSB  = 16;

  typedef enum logic [3:0] {
    IDLE,
    ADDR2,
    WDAT1,
    WDAT2,
    CMD_REQ,
    CMD_WAIT,
    WACK,
    RDAT1,
    RDAT2
  } mib_slv_state_t;

  typedef struct packed {
    logic                     rd_wr_n;
    logic [MIB_ADDR_BITS-1:0] addr;
    logic [MIB_DATA_BITS-1:0] wdata;
  } mib_cmd_t;

  function automatic logic [MIB_MSN_BITS-1:0] mib_addr_msn(input logic [MIB_ADDR_BITS-1:0] addr);
    return addr[MIB_MSN_LSB +: MIB_MSN_BITS];
  endfunction

endpackage

// File: rtl/mib_slave_bridge.sv
// MIB responder: decodes multiplexed address/data phases, replays them as one
// cmd-bus access and returns the write ack or the two read-data phases.
module mib_slave_bridge
  import mib_pkg::*;
#(
  parameter logic [3:0]  P_MIB_MSN              = 4'h0,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16,
  parameter int unsigned ADDR_BITS              = 24,
  parameter int unsigned DATA_BITS              = 32
) (
  input  logic                   i_sysclk,
  input  logic                   i_srst,
  input  logic                   i_mib_start,
  input  logic                   i_mib_rd_wr_n,
  input  logic [15:0]            i_mib_ad,
  output logic [15:0]            o_mib_ad,
  output logic                   o_mib_ad_high_z,
  output logic                   o_mib_slave_ack,
  output logic                   o_cmd_sel,
  output logic                   o_cmd_rd_wr_n,
  output logic [ADDR_BITS-1:0]   o_cmd_byte_addr,
  output logic [DATA_BITS-1:0]   o_cmd_wdata,
  input  logic                   i_cmd_ack,
  input  logic [DATA_BITS-1:0]   i_cmd_rdata,
  output logic                   o_cmd_timeout
);

  localparam int unsigned CNT_W = (P_CMD_ACK_TIMEOUT_CLKS > 1) ? $clog2(P_CMD_ACK_TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1);

  mib_slv_state_t           state_q, state_d;
  mib_cmd_t                 cmd_q, cmd_d;
  logic [MIB_DATA_BITS-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MIB_AD_BITS-1:0]   mib_ad_q, mib_ad_d;
  logic                     high_z_q, high_z_d;
  logic                     slave_ack_q, slave_ack_d;
  logic                     cmd_sel_q, cmd_sel_d;
  logic                     cmd_timeout_q, cmd_timeout_d;

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      mib_ad_q      <= '0;
      high_z_q      <= 1'b1;
      slave_ack_q   <= 1'b0;
      cmd_sel_q     <= 1'b0;
      cmd_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      mib_ad_q      <= mib_ad_d;
      high_z_q      <= high_z_d;
      slave_ack_q   <= slave_ack_d;
      cmd_sel_q     <= cmd_sel_d;
      cmd_timeout_q <= cmd_timeout_d;
    end
  end

  // Next state; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rdata_d       = rdata_q;
    cnt_d         = '0;
    cmd_timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_mib_start) begin
          state_d         = ADDR2;
          cmd_d.rd_wr_n   = i_mib_rd_wr_n;
          cmd_d.addr[MIB_ADDR_BITS-1:MIB_A1_ADDR_LSB] = i_mib_ad[MIB_A1_ADDR_BITS-1:0];
        end
      end
      ADDR2: begin
        cmd_d.addr[MIB_A1_ADDR_LSB-1:0] = i_mib_ad;
        if (mib_addr_msn(cmd_q.addr) != P_MIB_MSN) state_d = IDLE;
        else if (cmd_q.rd_wr_n)                    state_d = CMD_REQ;
        else                                       state_d = WDAT1;
      end
      WDAT1: begin
        cmd_d.wdata[MIB_DATA_BITS-1:MIB_AD_BITS] = i_mib_ad;
        state_d = WDAT2;
      end
      WDAT2: begin
        cmd_d.wdata[MIB_AD_BITS-1:0] = i_mib_ad;
        state_d = CMD_REQ;
      end
      CMD_REQ: begin
        // Counter tracks clocks since sel, so the last count clock is sel + N-1.
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = CMD_WAIT;
      end
      CMD_WAIT: begin
        if (i_cmd_ack) begin
          rdata_d = i_cmd_rdata;
          state_d = cmd_q.rd_wr_n ? RDAT1 : WACK;
        end else if (cnt_q == CNT_LAST) begin
          cmd_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WACK:    state_d = IDLE;
      RDAT1:   state_d = RDAT2;
      RDAT2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_sel_d   = (state_d == CMD_REQ);
    slave_ack_d = (state_d inside {WACK, RDAT1, RDAT2});
    high_z_d    = !(state_d inside {RDAT1, RDAT2});
    if (state_d == RDAT1)      mib_ad_d = rdata_d[MIB_DATA_BITS-1:MIB_AD_BITS];
    else if (state_d == RDAT2) mib_ad_d = rdata_d[MIB_AD_BITS-1:0];
    else                       mib_ad_d = '0;
  end

  assign o_mib_ad        = mib_ad_q;
  assign o_mib_ad_high_z = high_z_q;
  assign o_mib_slave_ack = slave_ack_q;
  assign o_cmd_sel       = cmd_sel_q;
  assign o_cmd_rd_wr_n   = cmd_q.rd_wr_n;
  assign o_cmd_byte_addr = cmd_q.addr;
  assign o_cmd_wdata     = cmd_q.wdata;
  assign o_cmd_timeout   = cmd_timeout_q;

endmodule

// File: tb/tb_mib_slave_bridge.sv
// Scoreboard bench for mib_slave_bridge: a transaction-level model predicts cmd
// requests, MIB responses and timeouts with their cycle numbers.
module tb_mib_slave_bridge;

  localparam logic [3:0] MSN = 4'h0;

  logic        clk = 1'b0;
  logic        i_srst;
  logic        i_mib_start;
  logic        i_mib_rd_wr_n;
  logic [15:0] i_mib_ad;
  logic [15:0] o_mib_ad;
  logic        o_mib_ad_high_z;
  logic        o_mib_slave_ack;
  logic        o_cmd_sel;
  logic        o_cmd_rd_wr_n;
  logic [23:0] o_cmd_byte_addr;
  logic [31:0] o_cmd_wdata;
  logic        i_cmd_ack;
  logic [31:0] i_cmd_rdata;
  logic        o_cmd_timeout;

  always #5 clk = ~clk;

  mib_slave_bridge #(.P_MIB_MSN(MSN), .P_CMD_ACK_TIMEOUT_CLKS(16)) dut (
    .i_sysclk(clk), .i_srst(i_srst),
    .i_mib_start(i_mib_start), .i_mib_rd_wr_n(i_mib_rd_wr_n), .i_mib_ad(i_mib_ad),
    .o_mib_ad(o_mib_ad), .o_mib_ad_high_z(o_mib_ad_high_z), .o_mib_slave_ack(o_mib_slave_ack),
    .o_cmd_sel(o_cmd_sel), .o_cmd_rd_wr_n(o_cmd_rd_wr_n), .o_cmd_byte_addr(o_cmd_byte_addr),
    .o_cmd_wdata(o_cmd_wdata), .i_cmd_ack(i_cmd_ack), .i_cmd_rdata(i_cmd_rdata),
    .o_cmd_timeout(o_cmd_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int cyc; logic rd; logic [23:0] addr; logic [31:0] wdata; } exp_cmd_t;
  typedef struct { int cyc; logic rd; logic [15:0] ad; } exp_rsp_t;

  exp_cmd_t    exp_cmd[$];
  exp_rsp_t    exp_rsp[$];
  int          exp_to[$];
  logic [31:0] ref_mem[int];
  logic [31:0] stub_mem[int];
  int          stub_dly = 1;
  bit          stub_busy = 0;

  function automatic logic [31:0] init_word(input logic [23:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues.
  exp_cmd_t mc;
  exp_rsp_t mr;
  int       mt;
  always @(negedge clk) begin
    if (o_cmd_sel) begin
      if (exp_cmd.size() == 0) flag("unexpected_sel");
      else begin
        mc = exp_cmd.pop_front();
        check("sel_cycle", 64'(cyc), 64'(mc.cyc));
        check("cmd_rd_wr_n", 64'(o_cmd_rd_wr_n), 64'(mc.rd));
        check("cmd_addr", 64'(o_cmd_byte_addr), 64'(mc.addr));
        if (!mc.rd) check("cmd_wdata", 64'(o_cmd_wdata), 64'(mc.wdata));
      end
    end
    if (o_mib_slave_ack) begin
      if (exp_rsp.size() == 0) flag("unexpected_ack");
      else begin
        mr = exp_rsp.pop_front();
        check("ack_cycle", 64'(cyc), 64'(mr.cyc));
        check("ack_high_z", 64'(o_mib_ad_high_z), 64'(!mr.rd));
        check("ack_ad", 64'(o_mib_ad), 64'(mr.ad));
      end
    end else begin
      check("idle_high_z", 64'(o_mib_ad_high_z), 64'd1);
      check("idle_ad", 64'(o_mib_ad), 64'd0);
    end
    if (o_cmd_timeout) begin
      if (exp_to.size() == 0) flag("unexpected_timeout");
      else begin
        mt = exp_to.pop_front();
        check("timeout_cycle", 64'(cyc), 64'(mt));
      end
    end
  end

  // cmd-bus stub: memory with a programmable ack delay (0 = never ack).
  initial begin
    logic [23:0] a;
    logic [31:0] rv;
    logic        rd;
    int          d;
    i_cmd_ack   = 1'b0;
    i_cmd_rdata = '0;
    forever begin
      @(negedge clk);
      if (o_cmd_sel) begin
        stub_busy = 1;
        a  = o_cmd_byte_addr;
        rd = o_cmd_rd_wr_n;
        d  = stub_dly;
        if (!rd) stub_mem[int'(a)] = o_cmd_wdata;
        rv = stub_mem.exists(int'(a)) ? stub_mem[int'(a)] : init_word(a);
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 i_cmd_ack = 1'b1;
          i_cmd_rdata = rd ? rv : $urandom;
          @(posedge clk);
          #1 i_cmd_ack = 1'b0;
          i_cmd_rdata = $urandom;
        end
        stub_busy = 0;
      end
    end
  end

  // Drives one MIB transaction and records what the spec says must follow.
  task automatic issue(input logic rd, input logic [23:0] addr, input logic [31:0] data, input int dly);
    int          t0, tsel;
    logic [31:0] rv;
    @(posedge clk);
    #1;
    t0 = cyc;
    stub_dly = dly;
    if (addr[23:20] == MSN) begin
      tsel = t0 + (rd ? 2 : 4);
      exp_cmd.push_back('{tsel, rd, addr, data});
      rv = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : init_word(addr);
      if (!rd) ref_mem[int'(addr)] = data;
      if (dly >= 1 && dly <= 15) begin
        if (rd) begin
          exp_rsp.push_back('{tsel + dly + 1, 1'b1, rv[31:16]});
          exp_rsp.push_back('{tsel + dly + 2, 1'b1, rv[15:0]});
        end else begin
          exp_rsp.push_back('{tsel + dly + 1, 1'b0, 16'h0000});
        end
      end else begin
        exp_to.push_back(tsel + 16);
      end
    end
    i_mib_start   = 1'b1;
    i_mib_rd_wr_n = rd;
    i_mib_ad      = {8'($urandom), addr[23:16]};
    @(posedge clk);
    #1 i_mib_start = 1'b0;
    i_mib_rd_wr_n = 1'($urandom);
    i_mib_ad      = addr[15:0];
    if (!rd) begin
      @(posedge clk);
      #1 i_mib_ad = data[31:16];
      @(posedge clk);
      #1 i_mib_ad = data[15:0];
    end
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 i_mib_ad = 16'($urandom);
      if (exp_cmd.size() == 0 && exp_rsp.size() == 0 && exp_to.size() == 0 && !stub_busy) break;
    end
    if (i == 200) flag("wait_done_budget");
  endtask

  task automatic wait_acks(input int n);
    int seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk);
      if (o_mib_slave_ack) seen++;
    end
    if (seen < n) flag("wait_ack_budget");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_high_z"}, 64'(o_mib_ad_high_z), 64'd1);
    check({tag, "_ad"}, 64'(o_mib_ad), 64'd0);
    check({tag, "_ack"}, 64'(o_mib_slave_ack), 64'd0);
    check({tag, "_sel"}, 64'(o_cmd_sel), 64'd0);
    check({tag, "_rd_wr_n"}, 64'(o_cmd_rd_wr_n), 64'd0);
    check({tag, "_addr"}, 64'(o_cmd_byte_addr), 64'd0);
    check({tag, "_wdata"}, 64'(o_cmd_wdata), 64'd0);
    check({tag, "_timeout"}, 64'(o_cmd_timeout), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rd;
    logic [3:0]  msn;
    logic [23:0] a;
    int          r, d;
    bit          got;
    i_srst        = 1'b1;
    i_mib_start   = 1'b0;
    i_mib_rd_wr_n = 1'b0;
    i_mib_ad      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 i_srst = 1'b0;

    // Directed write; a stray start while busy must be ignored.
    issue(1'b0, 24'h000004, 32'h01010202, 3);
    repeat (2) @(posedge clk);
    #1 i_mib_start = 1'b1;
    i_mib_rd_wr_n = 1'b1;
    i_mib_ad = 16'h0000;
    @(posedge clk);
    #1 i_mib_start = 1'b0;
    wait_done();

    issue(1'b1, 24'h000004, 32'h0, 2);
    wait_done();

    // Foreign MSN: no sel, no ack.
    issue(1'b0, 24'h100008, 32'hDEADBEEF, 3);
    wait_done();
    issue(1'b1, 24'h100008, 32'h0, 3);
    wait_done();

    // Timeout with no ack, then a normal write.
    issue(1'b0, 24'h000004, 32'h12345678, 0);
    wait_done();
    issue(1'b0, 24'h000008, 32'hCAFEF00D, 4);
    wait_done();

    // Ack on the final count clock wins; one clock later loses and is ignored.
    issue(1'b1, 24'h000008, 32'h0, 15);
    wait_done();
    issue(1'b0, 24'h00000C, 32'h0BADF00D, 16);
    wait_done();

    // Reset while waiting on a read ack.
    issue(1'b1, 24'h000010, 32'h0, 10);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_cmd_sel) got = 1;
    end
    if (!got) flag("reset_test_sel_budget");
    repeat (3) @(posedge clk);
    #1 i_srst = 1'b1;
    exp_rsp.delete();
    @(posedge clk);
    #1 i_srst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    wait_done();

    // Back-to-back: start on the first clock after WACK / RDAT2.
    issue(1'b0, 24'h000014, 32'hA1B2C3D4, 2);
    wait_acks(1);
    issue(1'b1, 24'h000014, 32'h0, 1);
    wait_acks(2);
    issue(1'b0, 24'h000018, 32'h55AA33CC, 5);
    wait_done();

    for (int n = 0; n < 40; n++) begin
      rd  = 1'($urandom);
      msn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : MSN;
      a   = {msn, 4'($urandom_range(0, 1)), 16'($urandom_range(0, 7) * 4)};
      r   = $urandom_range(0, 9);
      d   = (r == 0) ? 0 : (r == 1) ? 16 : $urandom_range(1, 15);
      issue(rd, a, $urandom, d);
      if (!rd && d >= 1 && d <= 15 && msn == MSN && $urandom_range(0, 1) == 1) wait_acks(1);
      else wait_done();
    end
    wait_done();
    repeat (5) @(posedge clk);

    check("exp_cmd_left", 64'(exp_cmd.size()), 64'd0);
    check("exp_rsp_left", 64'(exp_rsp.size()), 64'd0);
    check("exp_to_left", 64'(exp_to.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
